conv_operand_loader: RTL and testbench
======================================

Name: conv_operand_loader

Overview:
- Producer end of the convolution engine's operand interface.
- Accepts a byte stream and assembles one 4x4 data tile (16 bytes, 128-bit DATA) and one 3x3 filter (9 bytes, 72-bit FILTER).
- Presents both to the engine with a valid/ack handshake, then accepts the next frame.
- Sits between the host/memory byte source and the engine's DATA/FILTER inputs.

Parameters:
- DATA_BYTES, 16, bytes per data tile; DATA width = 8*DATA_BYTES.
- FILT_BYTES, 9, bytes per filter; FILTER width = 8*FILT_BYTES.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous soft abort of the current frame; frame_cnt is kept.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  operand byte.
- in_ready  out  1  loader can accept a byte.
- DATA  out  128  assembled data tile.
- FILTER  out  72  assembled filter.
- out_valid  out  1  DATA/FILTER complete and stable.
- out_ack  in  1  engine has consumed the operands.
- err  out  1  one-cycle checksum-error pulse (optional feature only; otherwise tied 0).
- frame_cnt  out  8  count of frames delivered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=LOAD_DATA, idx=0.
  - DATA=0, FILTER=0, out_valid=0, err=0, frame_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Byte transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = 1 in LOAD_DATA, LOAD_FILT and CHECK; 0 in PRESENT. It is a combinational decode of the registered state.
- States:
  - LOAD_DATA: byte k (k = 0..15) is written to DATA[8k+7:8k]; idx increments. After the byte at idx=15 is accepted: idx<=0, next state LOAD_FILT.
  - LOAD_FILT: byte k (k = 0..8) is written to FILTER[8k+7:8k]. After the byte at idx=8 is accepted: idx<=0, next state PRESENT (or CHECK when the optional feature is enabled).
  - PRESENT: out_valid=1. DATA and FILTER are held stable.
    - out_ack=1 at an edge: next state LOAD_DATA, out_valid<=0, frame_cnt<=frame_cnt+1 (wraps 255 to 0).
    - out_ack is ignored in every other state.
- Latency: last filter byte accepted at edge N gives out_valid=1 from edge N (visible cycle N+1). out_ack sampled at edge M gives out_valid=0 and in_ready=1 after edge M.
- DATA/FILTER update byte-wise during loading. Consumers use them only while out_valid=1. After ack they keep the old frame's values until overwritten.
- in_valid=0 stalls loading indefinitely with no timeout. Gaps between bytes are allowed.
- clr=1 at an edge:
  - state<=LOAD_DATA, idx<=0, out_valid<=0, err<=0.
  - DATA/FILTER are not cleared. A byte presented in the same cycle is discarded.
  - clr has priority over a transfer and over out_ack; frame_cnt does not increment.
- rst has priority over clr.
- Back-to-back frames: the first byte of the next frame may be accepted in the cycle immediately after the ack edge.

Optional Feature:
- Macro: CONV_LOADER_CKSUM_EN
- Defined:
  - Each frame carries a 26th byte, the XOR of all 25 operand bytes. It is accepted in state CHECK (in_ready=1).
  - A running XOR accumulator is cleared at frame start, on clr and on rst.
  - Match: next state PRESENT.
  - Mismatch: err=1 for exactly one cycle, state returns to LOAD_DATA with idx=0, frame_cnt unchanged, out_valid stays 0.
- Not defined: no CHECK state, no accumulator, err tied to 0, 25-byte frames.

Test Plan:
- Reset then stream bytes 0x00..0x18 continuously, no ack:
  - DATA=0x0F0E...0100.
  - FILTER=0x1817161514131211_10.
  - out_valid rises the cycle after byte 0x18; in_ready=0 and outputs stable for 10 cycles.
- Ack in the PRESENT state:
  - out_valid=0 and in_ready=1 the next cycle; frame_cnt 0 to 1.
  - A second frame streamed immediately completes with frame_cnt=2 after its ack.
- Stalls: in_valid toggling 1,0,0,1 on the same 25 bytes gives identical DATA/FILTER. Ack pulses outside PRESENT leave frame_cnt unchanged.
- clr asserted after 20 accepted bytes:
  - in_ready stays 1, idx=0, out_valid=0.
  - The next 25 bytes form a full frame; frame_cnt unchanged by the clr.
- Wrap and priority:
  - 256 delivered frames give frame_cnt=0.
  - clr and out_ack together in PRESENT: out_valid=0, frame_cnt unchanged.
  - rst and clr together give the full reset values.
- With CONV_LOADER_CKSUM_EN:
  - Checksum 0x18 (XOR of 0x00..0x18) gives out_valid.
  - Checksum 0x19 gives a one-cycle err pulse, no out_valid, and the next frame loads normally.

Source files
------------

// File: rtl/conv_operand_loader_if.sv
// ----------------------------------------------------------------------------
// conv_operand_loader_if
// Operand bus between the byte source / engine and conv_operand_loader.
//   in_valid, in_byte, in_ready : byte stream into the loader
//   DATA, FILTER                : assembled data tile and filter
//   out_valid, out_ack          : operand handshake towards the engine
//   err                         : checksum-error pulse (0 unless checksum build)
//   frame_cnt                   : number of frames delivered (wraps at 256)
// Modports: slave  = the loader itself
//           master = the environment (byte source plus engine)
// ----------------------------------------------------------------------------
interface conv_operand_loader_if #(
    parameter int DATA_BYTES = 16,
    parameter int FILT_BYTES = 9
);
    logic                    in_valid;
    logic [7:0]              in_byte;
    logic                    in_ready;
    logic [8*DATA_BYTES-1:0] DATA;
    logic [8*FILT_BYTES-1:0] FILTER;
    logic                    out_valid;
    logic                    out_ack;
    logic                    err;
    logic [7:0]              frame_cnt;

    modport slave (
        input  in_valid, in_byte, out_ack,
        output in_ready, DATA, FILTER, out_valid, err, frame_cnt
    );

    modport master (
        output in_valid, in_byte, out_ack,
        input  in_ready, DATA, FILTER, out_valid, err, frame_cnt
    );
endinterface

// File: rtl/conv_operand_loader.sv
// ----------------------------------------------------------------------------
// conv_operand_loader
// Producer end of the convolution engine operand interface. Assembles a byte
// stream into one data tile (DATA_BYTES bytes) and one filter (FILT_BYTES
// bytes), presents both with out_valid until out_ack, then loads the next
// frame. Byte k of each field lands in bits [8k+7:8k].
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (priority over clr)
//   clr  : synchronous abort of the current frame, frame_cnt kept
//   bus  : conv_operand_loader_if.slave (stream, operands, handshake, status)
// Optional feature, macro CONV_LOADER_CKSUM_EN:
//   each frame carries a trailing XOR checksum byte checked in state CHECK;
//   a mismatch pulses err for one cycle and drops the frame. When the macro
//   is undefined frames are 25 bytes and err is tied to 0.
// ----------------------------------------------------------------------------
module conv_operand_loader #(
    parameter int DATA_BYTES = 16,
    parameter int FILT_BYTES = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    conv_operand_loader_if.slave  bus
);
    localparam int MAX_BYTES = (DATA_BYTES > FILT_BYTES) ? DATA_BYTES : FILT_BYTES;
    localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);
    localparam logic [IDX_W-1:0] FILT_LAST = IDX_W'(FILT_BYTES - 1);

`ifdef CONV_LOADER_CKSUM_EN
    typedef enum logic [1:0] {LOAD_DATA, LOAD_FILT, PRESENT, CHECK} state_e;
`else
    typedef enum logic [1:0] {LOAD_DATA, LOAD_FILT, PRESENT} state_e;
`endif

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [8*DATA_BYTES-1:0] data_q, data_d;
    logic [8*FILT_BYTES-1:0] filt_q, filt_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    in_ready_w;
    logic                    take;
`ifdef CONV_LOADER_CKSUM_EN
    logic                    err_q, err_d;
    logic [7:0]              cks_q, cks_d;
`endif

    assign in_ready_w = (state_q != PRESENT);
    assign take       = bus.in_valid && in_ready_w;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
`ifdef CONV_LOADER_CKSUM_EN
        err_d   = 1'b0;
        cks_d   = cks_q;
`endif
        if (clr) begin
            // Abort wins over any transfer or ack this cycle; operands are kept.
            state_d = LOAD_DATA;
            idx_d   = '0;
`ifdef CONV_LOADER_CKSUM_EN
            cks_d   = '0;
`endif
        end else begin
            case (state_q)
                LOAD_DATA: begin
                    if (take) begin
                        data_d[{idx_q, 3'b000} +: 8] = bus.in_byte;
`ifdef CONV_LOADER_CKSUM_EN
                        // First byte of a frame restarts the running XOR.
                        cks_d = (idx_q == '0) ? bus.in_byte : (cks_q ^ bus.in_byte);
`endif
                        if (idx_q == DATA_LAST) begin
                            idx_d   = '0;
                            state_d = LOAD_FILT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                LOAD_FILT: begin
                    if (take) begin
                        filt_d[{idx_q, 3'b000} +: 8] = bus.in_byte;
`ifdef CONV_LOADER_CKSUM_EN
                        cks_d = cks_q ^ bus.in_byte;
`endif
                        if (idx_q == FILT_LAST) begin
                            idx_d = '0;
`ifdef CONV_LOADER_CKSUM_EN
                            state_d = CHECK;
`else
                            state_d = PRESENT;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
`ifdef CONV_LOADER_CKSUM_EN
                CHECK: begin
                    if (take) begin
                        if (bus.in_byte == cks_q) begin
                            state_d = PRESENT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = LOAD_DATA;
                        end
                    end
                end
`endif
                PRESENT: begin
                    if (bus.out_ack) begin
                        state_d = LOAD_DATA;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = LOAD_DATA;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_DATA;
            idx_q   <= '0;
            data_q  <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
`ifdef CONV_LOADER_CKSUM_EN
            err_q   <= 1'b0;
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
`ifdef CONV_LOADER_CKSUM_EN
            err_q   <= err_d;
            cks_q   <= cks_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.DATA      = data_q;
    assign bus.FILTER    = filt_q;
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.frame_cnt = cnt_q;
`ifdef CONV_LOADER_CKSUM_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_conv_operand_loader.sv
// ----------------------------------------------------------------------------
// tb_conv_operand_loader
// Directed self-checking bench for conv_operand_loader. Inputs are driven 1
// time unit after each rising edge and outputs are sampled at the same point.
// Define CONV_LOADER_CKSUM_EN for both bench and RTL to cover the checksum.
// ----------------------------------------------------------------------------
module tb_conv_operand_loader;
    localparam logic [127:0] DATA_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [71:0]  FILT_SEQ = 72'h181716151413121110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    conv_operand_loader_if #(.DATA_BYTES(16), .FILT_BYTES(9)) bus ();

    conv_operand_loader #(.DATA_BYTES(16), .FILT_BYTES(9)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    function automatic logic [127:0] exp_data(input logic [7:0] base);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    function automatic logic [71:0] exp_filt(input logic [7:0] base);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[8*k +: 8] = base + 8'(16 + k);
        return r;
    endfunction

    function automatic logic [7:0] exp_cks(input logic [7:0] base);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 25; k++) r = r ^ (base + 8'(k));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and wait (bounded) until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            total_cnt++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1 (byte %02h)", bus.in_ready, b);
        end else begin
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int k = 0; k < 25; k++) send_byte(base + 8'(k));
`ifdef CONV_LOADER_CKSUM_EN
        send_byte(exp_cks(base));
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic do_ack();
        bus.in_valid = 1'b0;
        bus.out_ack  = 1'b1;
        tick();
        bus.out_ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        total_cnt++;
        if (bus.DATA !== 128'h0 || bus.FILTER !== 72'h0) $display("FAIL reset_operands: DATA=%h FILTER=%h required 0", bus.DATA, bus.FILTER);
        else pass_cnt++;
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.err} !== 3'b010) $display("FAIL reset_flags: valid/ready/err=%b required 010", {bus.out_valid, bus.in_ready, bus.err});
        else pass_cnt++;
        total_cnt++;
        if (bus.frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %0d required 0", bus.frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 25; k++) begin
            send_byte(8'(k));
            if (k == 24) begin
                total_cnt++;
`ifdef CONV_LOADER_CKSUM_EN
                if (bus.out_valid !== 1'b0) $display("FAIL stream_valid_before_cks: got %0b required 0", bus.out_valid);
`else
                if (bus.out_valid !== 1'b1) $display("FAIL stream_valid_after_last: got %0b required 1", bus.out_valid);
`endif
                else pass_cnt++;
            end
            if (k == 23) begin
                total_cnt++;
                if (bus.out_valid !== 1'b0) $display("FAIL stream_valid_early: got %0b required 0", bus.out_valid);
                else pass_cnt++;
            end
        end
`ifdef CONV_LOADER_CKSUM_EN
        send_byte(8'h18);
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL cks_good_valid: got %0b required 1", bus.out_valid);
        else pass_cnt++;
`endif
        total_cnt++;
        if (bus.DATA !== DATA_SEQ) $display("FAIL stream_data: got %h required %h", bus.DATA, DATA_SEQ);
        else pass_cnt++;
        total_cnt++;
        if (bus.FILTER !== FILT_SEQ) $display("FAIL stream_filter: got %h required %h", bus.FILTER, FILT_SEQ);
        else pass_cnt++;
        // Keep offering bytes: the loader must hold everything while presenting.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hAA;
        for (int c = 0; c < 10; c++) begin
            total_cnt++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.DATA !== DATA_SEQ || bus.FILTER !== FILT_SEQ)
                $display("FAIL present_hold cycle %0d: ready=%0b valid=%0b DATA=%h FILTER=%h required ready 0 valid 1 and stream values",
                         c, bus.in_ready, bus.out_valid, bus.DATA, bus.FILTER);
            else pass_cnt++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_ack();
        do_ack();
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL ack_flags: valid=%0b ready=%0b required 0/1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.frame_cnt !== 8'd1) $display("FAIL ack_frame_cnt: got %0d required 1", bus.frame_cnt);
        else pass_cnt++;
        send_frame(8'h40);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.DATA !== exp_data(8'h40) || bus.FILTER !== exp_filt(8'h40))
            $display("FAIL b2b_frame: valid=%0b DATA=%h FILTER=%h required 1/%h/%h", bus.out_valid, bus.DATA, bus.FILTER, exp_data(8'h40), exp_filt(8'h40));
        else pass_cnt++;
        do_ack();
        total_cnt++;
        if (bus.frame_cnt !== 8'd2) $display("FAIL b2b_frame_cnt: got %0d required 2", bus.frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        for (int k = 0; k < 25; k++) begin
            send_byte(8'(k));
            if (k < 24) begin
                bus.in_valid = 1'b0;
                bus.out_ack  = 1'b1;
                repeat (2) tick();
                bus.out_ack  = 1'b0;
            end
        end
`ifdef CONV_LOADER_CKSUM_EN
        send_byte(8'h18);
`endif
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.DATA !== DATA_SEQ || bus.FILTER !== FILT_SEQ)
            $display("FAIL stall_frame: valid=%0b DATA=%h FILTER=%h required 1/%h/%h", bus.out_valid, bus.DATA, bus.FILTER, DATA_SEQ, FILT_SEQ);
        else pass_cnt++;
        total_cnt++;
        if (bus.frame_cnt !== 8'd2) $display("FAIL stall_ack_ignored: frame_cnt=%0d required 2", bus.frame_cnt);
        else pass_cnt++;
        do_ack();
        total_cnt++;
        if (bus.frame_cnt !== 8'd3) $display("FAIL stall_ack: frame_cnt=%0d required 3", bus.frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_clr();
        for (int k = 0; k < 20; k++) send_byte(8'h60 + 8'(k));
        bus.in_byte = 8'hEE;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL clr_flags: ready=%0b valid=%0b required 1/0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.DATA !== exp_data(8'h60) || bus.FILTER !== 72'h181716151473727170)
            $display("FAIL clr_keeps_operands: DATA=%h FILTER=%h required %h/181716151473727170", bus.DATA, bus.FILTER, exp_data(8'h60));
        else pass_cnt++;
        send_frame(8'h80);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.DATA !== exp_data(8'h80) || bus.FILTER !== exp_filt(8'h80))
            $display("FAIL clr_next_frame: valid=%0b DATA=%h FILTER=%h required 1/%h/%h", bus.out_valid, bus.DATA, bus.FILTER, exp_data(8'h80), exp_filt(8'h80));
        else pass_cnt++;
        total_cnt++;
        if (bus.frame_cnt !== 8'd3) $display("FAIL clr_frame_cnt: got %0d required 3", bus.frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_clr_ack_priority();
        bus.out_ack = 1'b1;
        clr = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        clr = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_cnt !== 8'd3)
            $display("FAIL clr_over_ack: valid=%0b ready=%0b frame_cnt=%0d required 0/1/3", bus.out_valid, bus.in_ready, bus.frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        for (int f = 0; f < 252; f++) begin
            send_frame(8'(f));
            do_ack();
        end
        total_cnt++;
        if (bus.frame_cnt !== 8'd255) $display("FAIL wrap_255: got %0d required 255", bus.frame_cnt);
        else pass_cnt++;
        send_frame(8'hC0);
        do_ack();
        total_cnt++;
        if (bus.frame_cnt !== 8'd0) $display("FAIL wrap_0: got %0d required 0", bus.frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_rst_clr();
        send_frame(8'h10);
        do_ack();
        for (int k = 0; k < 5; k++) send_byte(8'h90 + 8'(k));
        bus.in_byte = 8'h55;
        rst = 1'b1;
        clr = 1'b1;
        tick();
        rst = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.DATA !== 128'h0 || bus.FILTER !== 72'h0 || bus.frame_cnt !== 8'd0)
            $display("FAIL rst_clr_values: DATA=%h FILTER=%h frame_cnt=%0d required 0/0/0", bus.DATA, bus.FILTER, bus.frame_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.err} !== 3'b010) $display("FAIL rst_clr_flags: valid/ready/err=%b required 010", {bus.out_valid, bus.in_ready, bus.err});
        else pass_cnt++;
    endtask

`ifdef CONV_LOADER_CKSUM_EN
    task automatic test_cksum_bad();
        for (int k = 0; k < 25; k++) send_byte(8'(k));
        send_byte(8'h19);
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.err !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL cks_bad_pulse: err=%0b valid=%0b ready=%0b required 1/0/1", bus.err, bus.out_valid, bus.in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL cks_bad_one_cycle: err=%0b valid=%0b required 0/0", bus.err, bus.out_valid);
        else pass_cnt++;
        send_frame(8'h33);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.DATA !== exp_data(8'h33) || bus.FILTER !== exp_filt(8'h33) || bus.frame_cnt !== 8'd0)
            $display("FAIL cks_recover: valid=%0b DATA=%h FILTER=%h frame_cnt=%0d required 1/%h/%h/0",
                     bus.out_valid, bus.DATA, bus.FILTER, bus.frame_cnt, exp_data(8'h33), exp_filt(8'h33));
        else pass_cnt++;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.out_ack  = 1'b0;
        test_reset();
        test_stream();
        test_ack();
        test_stall();
        test_clr();
        test_clr_ack_priority();
        test_wrap();
        test_rst_clr();
`ifdef CONV_LOADER_CKSUM_EN
        test_cksum_bad();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
